irom_port_arbiter: RTL and testbench

- Shares the single synchronous i_rom read port between two requesters: front-end fetch (FE) and a secondary load requester (LD), e.g. PC-relative literal loads or a debug/program reader.
- FE has default priority. LD is guaranteed service within a bounded wait by an anti-starvation counter.
- Tracks the one in-flight read (1-cycle ROM latency) and routes the returned word to its owner.
- Drops FE responses killed by a redirect (mispredict or taken branch).

---
 rtl/irom_port_arbiter.sv | 93 +++++++++
 tb/tb_irom_port_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/irom_port_arbiter.sv
// Arbiter that lets two requesters share the one synchronous i_rom read port.
// Front-end fetch (FE) has priority by default. The secondary load requester (LD)
// is forced through after MAX_WAIT_P consecutive denied cycles. One read is in
// flight at a time. Its returned word is steered to the requester that issued it.
// A redirect kills FE traffic.
module irom_port_arbiter #(
    parameter int WORD_SIZE_P = 16,
    parameter int MAX_WAIT_P  = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   fe_v_i,
    input  logic [WORD_SIZE_P-1:0] fe_addr_i,
    output logic                   fe_ready_o,
    input  logic                   fe_flush_i,
    output logic                   fe_v_o,
    output logic [WORD_SIZE_P-1:0] fe_data_o,
    input  logic                   ld_v_i,
    input  logic [WORD_SIZE_P-1:0] ld_addr_i,
    output logic                   ld_ready_o,
    output logic                   ld_v_o,
    output logic [WORD_SIZE_P-1:0] ld_data_o,
    output logic                   rom_en_o,
    output logic [WORD_SIZE_P-1:0] rom_addr_o,
    input  logic [WORD_SIZE_P-1:0] rom_data_i
);

    localparam int CNT_W = (MAX_WAIT_P < 1) ? 1 : $clog2(MAX_WAIT_P + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT_P);

    // Records who owns the word that the ROM returns in the current cycle.
    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        FE_INFLIGHT = 2'd1,
        FE_KILLED   = 2'd2,
        LD_INFLIGHT = 2'd3
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic             force_ld;

    // LD has waited long enough, so it wins over FE this cycle.
    assign force_ld = ld_v_i && (wait_cnt_reg == MAX_CNT);

    // Grant logic. There is at most one grant per cycle, and it drives the ROM port directly.
    always_comb begin
        ld_ready_o = ld_v_i && (!fe_v_i || force_ld);
        fe_ready_o = fe_v_i && !ld_ready_o;
        rom_en_o   = fe_ready_o || ld_ready_o;
        rom_addr_o = ld_ready_o ? ld_addr_i : fe_addr_i;
    end

    // Next-state logic for the owner tracker and the LD starvation counter.
    always_comb begin
        state_next    = IDLE;
        wait_cnt_next = wait_cnt_reg;

        if (ld_ready_o) begin
            state_next = LD_INFLIGHT;
        end else if (fe_ready_o) begin
            // An FE read accepted while a redirect is active is still issued to
            // the ROM. Its returned word is dropped.
            state_next = fe_flush_i ? FE_KILLED : FE_INFLIGHT;
        end

        if (!ld_v_i || ld_ready_o) begin
            wait_cnt_next = '0;
        end else if (wait_cnt_reg != MAX_CNT) begin
            wait_cnt_next = wait_cnt_reg + 1'b1;
        end
    end

    // State registers. Reset discards any read that is in flight.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_reg    <= IDLE;
            wait_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    // Response steering. Data is zeroed whenever the matching valid is low.
    always_comb begin
        fe_v_o    = (state_reg == FE_INFLIGHT) && !fe_flush_i;
        ld_v_o    = (state_reg == LD_INFLIGHT);
        fe_data_o = fe_v_o ? rom_data_i : '0;
        ld_data_o = ld_v_o ? rom_data_i : '0;
    end

endmodule

// File: tb/tb_irom_port_arbiter.sv
// Testbench for irom_port_arbiter. It applies a table of per-cycle vectors with
// the expected grant in each row. A scoreboard queue holds the response expected
// one cycle after each grant. A hand-written sequence covers asynchronous reset
// while a read is in flight.
module tb_irom_port_arbiter;

    logic        clk_i = 1'b0;
    logic        reset_n_i = 1'b0;
    logic        fe_v_i = 1'b0;
    logic [15:0] fe_addr_i = '0;
    logic        fe_ready_o;
    logic        fe_flush_i = 1'b0;
    logic        fe_v_o;
    logic [15:0] fe_data_o;
    logic        ld_v_i = 1'b0;
    logic [15:0] ld_addr_i = '0;
    logic        ld_ready_o;
    logic        ld_v_o;
    logic [15:0] ld_data_o;
    logic        rom_en_o;
    logic [15:0] rom_addr_o;
    logic [15:0] rom_data_i = '0;

    irom_port_arbiter #(.WORD_SIZE_P(16), .MAX_WAIT_P(4)) dut (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .fe_v_i     (fe_v_i),
        .fe_addr_i  (fe_addr_i),
        .fe_ready_o (fe_ready_o),
        .fe_flush_i (fe_flush_i),
        .fe_v_o     (fe_v_o),
        .fe_data_o  (fe_data_o),
        .ld_v_i     (ld_v_i),
        .ld_addr_i  (ld_addr_i),
        .ld_ready_o (ld_ready_o),
        .ld_v_o     (ld_v_o),
        .ld_data_o  (ld_data_o),
        .rom_en_o   (rom_en_o),
        .rom_addr_o (rom_addr_o),
        .rom_data_i (rom_data_i)
    );

    always #5 clk_i = ~clk_i;

    // ROM contents: address + 0x100, except that 0x0040 holds 0xBEEF.
    function automatic logic [15:0] rom_fn(input logic [15:0] a);
        return (a == 16'h0040) ? 16'hBEEF : a + 16'h0100;
    endfunction

    // Synchronous ROM with one cycle of latency. It holds its output when not enabled.
    always @(posedge clk_i) begin
        if (rom_en_o) rom_data_i <= rom_fn(rom_addr_o);
    end

    localparam logic [1:0] G_NONE = 2'd0, G_FE = 2'd1, G_LD = 2'd2;

    typedef struct {
        logic        fe_v;
        logic [15:0] fe_addr;
        logic        ld_v;
        logic [15:0] ld_addr;
        logic        flush;
        logic [1:0]  gnt;
    } vec_t;

    typedef struct {
        logic        fe;
        logic        ld;
        logic [15:0] data;
    } rsp_t;

    vec_t vecs[$];
    rsp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic add(input logic fv, input logic [15:0] fa, input logic lv,
                       input logic [15:0] la, input logic fl, input logic [1:0] g);
        vec_t v;
        v.fe_v = fv; v.fe_addr = fa; v.ld_v = lv; v.ld_addr = la; v.flush = fl; v.gnt = g;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_idle();
        rsp_t r;
        r.fe = 1'b0; r.ld = 1'b0; r.data = '0;
        sb.push_back(r);
    endtask

    // Compares the response expected in the current cycle against the DUT outputs.
    task automatic check_rsp(input logic flush_now);
        rsp_t r;
        logic ef, el;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        r  = sb.pop_front();
        ef = r.fe && !flush_now;
        el = r.ld;
        chk("fe_v_o", 32'(fe_v_o), 32'(ef));
        chk("ld_v_o", 32'(ld_v_o), 32'(el));
        chk("fe_data_o", 32'(fe_data_o), ef ? 32'(r.data) : 32'd0);
        chk("ld_data_o", 32'(ld_data_o), el ? 32'(r.data) : 32'd0);
    endtask

    // Runs one cycle: drive the inputs, check the grant and the response, and queue the next expected response.
    task automatic step(input int idx);
        vec_t        v;
        rsp_t        r;
        logic [15:0] ea;
        v = vecs[idx];
        @(posedge clk_i);
        #1;
        fe_v_i = v.fe_v; fe_addr_i = v.fe_addr;
        ld_v_i = v.ld_v; ld_addr_i = v.ld_addr;
        fe_flush_i = v.flush;
        @(negedge clk_i);
        ea = (v.gnt == G_LD) ? v.ld_addr : v.fe_addr;
        chk("fe_ready_o", 32'(fe_ready_o), 32'(v.gnt == G_FE));
        chk("ld_ready_o", 32'(ld_ready_o), 32'(v.gnt == G_LD));
        chk("rom_en_o", 32'(rom_en_o), 32'(v.gnt != G_NONE));
        if (v.gnt != G_NONE) chk("rom_addr_o", 32'(rom_addr_o), 32'(ea));
        check_rsp(v.flush);
        $display("vec %0d: gnt fe=%0b ld=%0b addr=%04h | rsp fe=%0b/%04h ld=%0b/%04h",
                 idx, fe_ready_o, ld_ready_o, rom_addr_o, fe_v_o, fe_data_o, ld_v_o, ld_data_o);
        r.fe   = (v.gnt == G_FE) && !v.flush;
        r.ld   = (v.gnt == G_LD);
        r.data = rom_fn(ea);
        sb.push_back(r);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    int split;

    initial begin
        // FE-only stream.
        for (int i = 0; i < 4; i++) add(1, 16'(i), 0, 0, 0, G_FE);
        add(0, 0, 0, 0, 0, G_NONE);
        // LD-only single request.
        add(0, 0, 1, 16'h0040, 0, G_LD);
        add(0, 0, 0, 0, 0, G_NONE);
        // Starvation: FE x4, forced LD, FE x4, forced LD. Addresses are held while a request is denied.
        add(1, 16'h0050, 1, 16'h0060, 0, G_FE);
        add(1, 16'h0051, 1, 16'h0060, 0, G_FE);
        add(1, 16'h0052, 1, 16'h0060, 0, G_FE);
        add(1, 16'h0053, 1, 16'h0060, 0, G_FE);
        add(1, 16'h0054, 1, 16'h0060, 0, G_LD);
        add(1, 16'h0054, 1, 16'h0061, 0, G_FE);
        add(1, 16'h0055, 1, 16'h0061, 0, G_FE);
        add(1, 16'h0056, 1, 16'h0061, 0, G_FE);
        add(1, 16'h0057, 1, 16'h0061, 0, G_FE);
        add(1, 16'h0058, 1, 16'h0061, 0, G_LD);
        add(0, 0, 0, 0, 0, G_NONE);
        // Flush kills the returning FE word and the FE request accepted in the same cycle.
        add(1, 16'h0010, 0, 0, 0, G_FE);
        add(1, 16'h0011, 0, 0, 1, G_FE);
        add(1, 16'h0020, 0, 0, 0, G_FE);
        add(0, 0, 0, 0, 0, G_NONE);
        // Flush does not affect an LD read in flight.
        add(0, 0, 1, 16'h0030, 0, G_LD);
        add(0, 0, 0, 0, 1, G_NONE);
        add(0, 0, 0, 0, 0, G_NONE);
        // Flush in the same cycle as a forced LD grant: LD proceeds and FE stalls.
        for (int i = 0; i < 4; i++) add(1, 16'h0070 + 16'(i), 1, 16'h0078, 0, G_FE);
        add(1, 16'h0074, 1, 16'h0078, 1, G_LD);
        add(1, 16'h0074, 0, 0, 0, G_FE);
        add(0, 0, 0, 0, 0, G_NONE);
        // Last vector before the reset sequence: an LD accept.
        add(0, 0, 1, 16'h0040, 0, G_LD);
        split = vecs.size();
        // After reset: no stale response, and the counter restarts from zero.
        add(0, 0, 0, 0, 0, G_NONE);
        for (int i = 0; i < 4; i++) add(1, 16'h0090 + 16'(i), 1, 16'h00A0, 0, G_FE);
        add(1, 16'h0094, 1, 16'h00A0, 0, G_LD);
        add(0, 0, 0, 0, 0, G_NONE);

        // Reset state.
        #2;
        chk("reset_fe_v_o", 32'(fe_v_o), 32'd0);
        chk("reset_ld_v_o", 32'(ld_v_o), 32'd0);
        chk("reset_fe_data_o", 32'(fe_data_o), 32'd0);
        chk("reset_ld_data_o", 32'(ld_data_o), 32'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        push_idle();

        for (int i = 0; i < split; i++) step(i);

        // The LD response is visible, then reset is asserted mid-cycle.
        @(posedge clk_i);
        #1;
        fe_v_i = 0; ld_v_i = 0; fe_flush_i = 0;
        #1;
        check_rsp(1'b0);
        $display("rsp before reset: ld=%0b/%04h", ld_v_o, ld_data_o);
        #1;
        reset_n_i = 1'b0;
        #1;
        chk("async_rst_ld_v_o", 32'(ld_v_o), 32'd0);
        chk("async_rst_ld_data_o", 32'(ld_data_o), 32'd0);
        chk("async_rst_fe_v_o", 32'(fe_v_o), 32'd0);
        chk("async_rst_fe_data_o", 32'(fe_data_o), 32'd0);
        $display("rsp during reset: fe=%0b ld=%0b", fe_v_o, ld_v_o);
        @(posedge clk_i);
        @(posedge clk_i);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        sb.delete();
        push_idle();

        for (int i = split; i < vecs.size(); i++) step(i);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
